// File: rtl/dma_wr_req_width_conv.sv
// DMA write-request width down-converter: each wide beat is split into RATIO narrow slices, LSB first.
// Optional output skid buffer (registered outputs, 1-cycle latency) enabled by `DMA_WR_REQ_OUT_REG_EN.
module dma_wr_req_width_conv #(
  parameter int IN_DATA_W  = 512,
  parameter int OUT_DATA_W = 256,
  parameter int HEAD_W     = 128,
  parameter int LEN_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_wr_req_in_valid,
  input  logic [HEAD_W-1:0]     dma_wr_req_in_head,
  input  logic [IN_DATA_W-1:0]  dma_wr_req_in_data,
  input  logic                  dma_wr_req_in_last,
  output logic                  dma_wr_req_in_ready,
  output logic                  dma_wr_req_out_valid,
  output logic [HEAD_W-1:0]     dma_wr_req_out_head,
  output logic [OUT_DATA_W-1:0] dma_wr_req_out_data,
  output logic                  dma_wr_req_out_last,
  input  logic                  dma_wr_req_out_ready,
  output logic                  dma_wr_req_err
);

  localparam int RATIO  = IN_DATA_W / OUT_DATA_W;
  localparam int SIDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LEN_W-1:0]  OUT_BYTES_L = LEN_W'(OUT_DATA_W / 8);
  localparam logic [SIDX_W-1:0] SIDX_MAX    = SIDX_W'(RATIO - 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [SIDX_W-1:0]              sidx_q, sidx_d;
  logic [LEN_W-1:0]               len_left_q, len_left_d;
  logic                           err_q, err_d;
  logic [LEN_W-1:0]               eff_len_s;
  logic                           final_s;
  logic                           last_slice_s;
  logic                           sink_ready_s;
  logic                           conv_hs_s;
  logic                           in_hs_s;
  logic [RATIO-1:0][OUT_DATA_W-1:0] slices_s;
  logic [OUT_DATA_W-1:0]          slice_s;

  assign dma_wr_req_err = err_q;

  // Current slice selection and packet-end decode from the effective length
  always_comb begin
    slices_s = dma_wr_req_in_data;
    slice_s  = slices_s[sidx_q];
    if (state_q == IDLE) begin
      eff_len_s = dma_wr_req_in_head[LEN_W-1:0];
    end else begin
      eff_len_s = len_left_q;
    end
    final_s      = (eff_len_s <= OUT_BYTES_L);
    last_slice_s = (sidx_q == SIDX_MAX) || final_s;
    conv_hs_s    = dma_wr_req_in_valid && sink_ready_s && !rst;
    in_hs_s      = conv_hs_s && last_slice_s;
  end

  // Converter next state: advance one slice per accepted output beat
  always_comb begin
    state_d    = state_q;
    sidx_d     = sidx_q;
    len_left_d = len_left_q;
    if (conv_hs_s) begin
      if (final_s) begin
        len_left_d = '0;
        sidx_d     = '0;
        state_d    = IDLE;
      end else begin
        len_left_d = eff_len_s - OUT_BYTES_L;
        sidx_d     = (sidx_q == SIDX_MAX) ? '0 : sidx_q + SIDX_W'(1);
        state_d    = XFER;
      end
    end else begin
      state_d = state_q;
    end
    // in_last must agree with the length-derived end of packet
    if (in_hs_s) begin
      err_d = (dma_wr_req_in_last != final_s);
    end else begin
      err_d = 1'b0;
    end
  end

  // Converter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sidx_q     <= '0;
      len_left_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sidx_q     <= sidx_d;
      len_left_q <= len_left_d;
      err_q      <= err_d;
    end
  end

`ifdef DMA_WR_REQ_OUT_REG_EN
  logic                  v0_q, v0_d, v1_q, v1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic [HEAD_W-1:0]     head0_q, head0_d, head1_q, head1_d;
  logic [OUT_DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  pop_s;

  assign dma_wr_req_out_valid = v0_q;
  assign dma_wr_req_out_head  = head0_q;
  assign dma_wr_req_out_data  = data0_q;
  assign dma_wr_req_out_last  = last0_q;

  // Two-entry skid buffer; entry 0 always drives the outputs
  always_comb begin
    sink_ready_s = !v1_q;
    pop_s        = v0_q && dma_wr_req_out_ready;
    v0_d    = v0_q;
    v1_d    = v1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    head0_d = head0_q;
    head1_d = head1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    case ({v1_q, v0_q})
      2'b00: begin
        if (conv_hs_s) begin
          v0_d    = 1'b1;
          head0_d = dma_wr_req_in_head;
          data0_d = slice_s;
          last0_d = final_s;
        end else begin
          v0_d = 1'b0;
        end
      end
      2'b01: begin
        if (conv_hs_s && pop_s) begin
          head0_d = dma_wr_req_in_head;
          data0_d = slice_s;
          last0_d = final_s;
        end else if (conv_hs_s) begin
          v1_d    = 1'b1;
          head1_d = dma_wr_req_in_head;
          data1_d = slice_s;
          last1_d = final_s;
        end else if (pop_s) begin
          v0_d    = 1'b0;
          last0_d = 1'b0;
        end else begin
          v0_d = 1'b1;
        end
      end
      2'b11: begin
        if (pop_s) begin
          v1_d    = 1'b0;
          head0_d = head1_q;
          data0_d = data1_q;
          last0_d = last1_q;
        end else begin
          v1_d = 1'b1;
        end
      end
      default: begin
        v0_d    = 1'b0;
        v1_d    = 1'b0;
        last0_d = 1'b0;
      end
    endcase
    dma_wr_req_in_ready = !rst && !v1_q && last_slice_s;
  end

  // Skid buffer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      head0_q <= '0;
      head1_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      head0_q <= head0_d;
      head1_q <= head1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end
`else
  // Zero-latency output path, forced to zero while reset is asserted
  always_comb begin
    sink_ready_s = dma_wr_req_out_ready;
    if (rst) begin
      dma_wr_req_out_valid = 1'b0;
      dma_wr_req_out_head  = '0;
      dma_wr_req_out_data  = '0;
      dma_wr_req_out_last  = 1'b0;
      dma_wr_req_in_ready  = 1'b0;
    end else begin
      dma_wr_req_out_valid = dma_wr_req_in_valid;
      dma_wr_req_out_head  = dma_wr_req_in_head;
      dma_wr_req_out_data  = slice_s;
      dma_wr_req_out_last  = dma_wr_req_in_valid && final_s;
      dma_wr_req_in_ready  = dma_wr_req_out_ready && last_slice_s;
    end
  end
`endif

endmodule

// File: doc/dma_wr_req_width_conv.md
# dma_wr_req_width_conv

Parametrised DMA write-request width down-converter. It splits each wide input data beat into `RATIO = IN_DATA_W/OUT_DATA_W` narrow output beats, LSB slice first. It emits only the slices the packet's byte length requires, and it accepts back-to-back packets with no idle cycle between them. It sits between the wide internal DMA write path and a narrower PCIe/DMA engine port, and replaces the fixed 512→256 converter.

## Interface
- `IN_DATA_W`, default 512: input data width in bits.
- `OUT_DATA_W`, default 256: output data width in bits. `IN_DATA_W` must be an integer multiple of `OUT_DATA_W`, and `RATIO` must be a power of 2 (≥1).
- `HEAD_W`, default 128: header width in bits. `head[LEN_W-1:0]` holds the payload byte length.
- `LEN_W`, default 32: width of the length field.
- `clk` in, 1: the single clock.
- `rst` in, 1: asynchronous, active-high reset.
- `dma_wr_req_in_valid` in, 1: input beat valid.
- `dma_wr_req_in_head` in, HEAD_W: header, held stable for every beat of the packet.
- `dma_wr_req_in_data` in, IN_DATA_W: input data beat.
- `dma_wr_req_in_last` in, 1: final input beat of the packet. Checked only, never used for framing.
- `dma_wr_req_in_ready` out, 1: input beat consumed when `valid && ready`.
- `dma_wr_req_out_valid` out, 1: output beat valid.
- `dma_wr_req_out_head` out, HEAD_W: copy of the input header on every output beat.
- `dma_wr_req_out_data` out, OUT_DATA_W: current output slice.
- `dma_wr_req_out_last` out, 1: final output beat of the packet.
- `dma_wr_req_out_ready` in, 1: downstream accept.
- `dma_wr_req_err` out, 1: one-cycle pulse on a framing error.

## Operation
- `OUT_BYTES = OUT_DATA_W/8`. A packet produces `N = max(1, ceil(len/OUT_BYTES))` output beats.
- Length 0 produces one beat carrying slice 0, with `last=1`.
- State machine has two states:
  - `IDLE`: waiting for the first beat of a packet.
  - `XFER`: packet in progress.
- The effective length is `head[LEN_W-1:0]` in `IDLE` and the registered `len_left` in `XFER`. The first slice is therefore emitted in the same cycle the header arrives, with no bubble.
- Slice index `sidx` has width log2(RATIO), or is constant 0 when `RATIO=1`. Output data is `in_data[sidx*OUT_DATA_W +: OUT_DATA_W]`.
- `final` = effective length ≤ OUT_BYTES.
- On each output handshake:
  - `len_left` ← effective length − OUT_BYTES, saturating at 0.
  - `sidx` ← `sidx+1`, wrapping to 0 at RATIO−1.
  - If `final`: `sidx` ← 0 and state ← `IDLE`. Otherwise state ← `XFER`.
- `in_ready = out_ready && (sidx==RATIO-1 || final)`. A partially used wide beat is consumed on the final slice; the remaining slices are discarded.
- `out_last = out_valid && final`.
- `dma_wr_req_err` pulses for one cycle after an input handshake in either of these cases:
  - `in_last=1` on a non-final input beat.
  - `in_last=0` on the final input beat.
  - Framing still follows the length field in both cases.
- Length arithmetic is `LEN_W` bits unsigned. Length values up to 2^LEN_W−1 are legal.

## Timing
- Reset values:
  - state `IDLE`, `sidx=0`, `len_left=0`, `err=0`.
  - All outputs 0, including `in_ready`. `out_head` and `out_data` are also 0.
- Without the register option:
  - `out_valid`, `out_data`, `out_head`, `out_last` and `in_ready` are combinational from the inputs and the state.
  - Latency is 0 cycles. Throughput is 1 slice per cycle.
- Once `out_valid=1` is presented, slice data and `last` stay stable until the handshake, provided upstream holds its beat stable (AXI-style rule).
- `out_ready=0` holds all state.
- Back-to-back packets: the cycle after a `final` handshake is in `IDLE`, and it may already emit slice 0 of the next packet.
- Reset asserted mid-packet: immediate return to `IDLE`. The remainder of the packet is lost, and no `last` is emitted.

## Configuration
- `DMA_WR_REQ_OUT_REG_EN` defined:
  - Adds a 2-entry skid buffer on the output (valid/head/data/last).
  - All outputs are registered, latency 1 cycle, full throughput sustained.
  - `in_ready` depends only on skid-buffer occupancy and the converter state, and is not combinational from `out_ready`.
  - Skid buffer resets to empty.
- Undefined: purely combinational output path as described under Timing.

## Test plan
- 512→256, len=64, one input beat with `last=1`, `out_ready=1`: 2 out beats (data[255:0], then data[511:256]), `last` on beat 2, `in_ready` high only in the 2nd cycle, no `err`.
- 512→256, len=20: 1 out beat with `last=1`, the input beat consumed in the same cycle, upper half discarded.
- len=0 header with `in_last=1`: exactly 1 out beat (slice 0) with `last=1`.
- IN=512, OUT=128, len=100 over two input beats: 7 out beats (4 slices from beat 0, 3 from beat 1), `last` on the 7th. Then a second packet back-to-back with no idle cycle, `out_ready` randomly toggled; output matches the scoreboard.
- len=64 but `in_last=0` on the only input beat: framing is unchanged and `dma_wr_req_err` pulses for exactly 1 cycle.
- Assert `rst` after the first of 2 slices: outputs go to 0 immediately. After release, a new len=32 packet produces 1 beat with `last=1`. Repeat all cases with `DMA_WR_REQ_OUT_REG_EN` defined, expecting a +1 cycle shift.
